// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode / ID-EX register signals of id_ex_stage.
//   master : the surrounding pipeline (fetch, register file, writeback,
//            branch unit, execute stage).
//   slave  : the id_ex_stage block itself.
// Groups:
//   fetch     : if_valid, if_instr, stall
//   regfile   : rf_read1, rf_read2, rf_data1, rf_data2
//   writeback : wb_we, wb_rd, wb_data
//   execute   : ex_flush, ex_valid, ex_op, ex_funct, ex_rs_data, ex_rt_data,
//               ex_imm, ex_dest, ex_reg_write, ex_is_load
//   status    : stall_count
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  if_valid;
  logic [31:0]           if_instr;
  logic                  ex_flush;
  logic [4:0]            rf_read1;
  logic [4:0]            rf_read2;
  logic [DATA_WIDTH-1:0] rf_data1;
  logic [DATA_WIDTH-1:0] rf_data2;
  logic                  wb_we;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  stall;
  logic                  ex_valid;
  logic [5:0]            ex_op;
  logic [5:0]            ex_funct;
  logic [DATA_WIDTH-1:0] ex_rs_data;
  logic [DATA_WIDTH-1:0] ex_rt_data;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [4:0]            ex_dest;
  logic                  ex_reg_write;
  logic                  ex_is_load;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output if_valid, if_instr, ex_flush, rf_data1, rf_data2,
           wb_we, wb_rd, wb_data,
    input  rf_read1, rf_read2, stall, ex_valid, ex_op, ex_funct,
           ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_reg_write,
           ex_is_load, stall_count
  );

  modport slave (
    input  if_valid, if_instr, ex_flush, rf_data1, rf_data2,
           wb_we, wb_rd, wb_data,
    output rf_read1, rf_read2, stall, ex_valid, ex_op, ex_funct,
           ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_reg_write,
           ex_is_load, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode stage plus ID/EX pipeline register in front of a 32x32 register file.
// Splits the MIPS instruction, drives the register file read addresses,
// bypasses the same-cycle writeback value, stalls one cycle on a load-use
// dependency and registers operands/control for execute.
// Ports:
//   clk   : rising-edge clock (shared with the register file)
//   reset : synchronous, active-high
//   bus   : id_ex_stage_if.slave (fetch, regfile, writeback, execute, status)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  // Instruction fields
  logic [5:0]  op_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [5:0]  funct_s;
  logic [15:0] imm16_s;

  assign op_s    = bus.if_instr[31:26];
  assign rs_s    = bus.if_instr[25:21];
  assign rt_s    = bus.if_instr[20:16];
  assign rd_s    = bus.if_instr[15:11];
  assign funct_s = bus.if_instr[5:0];
  assign imm16_s = bus.if_instr[15:0];

  // Register file addresses come straight from the fetched word, even when
  // if_valid is low, so the read data is ready in the same cycle.
  assign bus.rf_read1 = rs_s;
  assign bus.rf_read2 = rt_s;

  // Decode results
  logic                  rw_raw_s;
  logic                  uses_rt_s;
  logic [4:0]            dest_s;
  logic                  reg_write_s;
  logic                  is_load_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] opa_s;
  logic [DATA_WIDTH-1:0] opb_s;
  logic                  hz_s;
  logic                  stall_s;

  // ID/EX register state
  logic                  ex_valid_q,     ex_valid_d;
  logic [5:0]            ex_op_q,        ex_op_d;
  logic [5:0]            ex_funct_q,     ex_funct_d;
  logic [DATA_WIDTH-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_WIDTH-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_WIDTH-1:0] ex_imm_q,       ex_imm_d;
  logic [4:0]            ex_dest_q,      ex_dest_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_is_load_q,   ex_is_load_d;
  logic [CNT_WIDTH-1:0]  stall_count_q,  stall_count_d;

  // Opcode classification: which opcodes write a register / read rt.
  always_comb begin
    rw_raw_s  = 1'b0;
    uses_rt_s = 1'b0;
    case (op_s)
      6'h00: begin rw_raw_s = 1'b1; uses_rt_s = 1'b1; end  // R-type
      6'h23: rw_raw_s  = 1'b1;                             // lw
      6'h08: rw_raw_s  = 1'b1;                             // addi
      6'h0A: rw_raw_s  = 1'b1;                             // slti
      6'h0C: rw_raw_s  = 1'b1;                             // andi
      6'h0D: rw_raw_s  = 1'b1;                             // ori
      6'h2B: uses_rt_s = 1'b1;                             // sw
      6'h04: uses_rt_s = 1'b1;                             // beq
      default: begin rw_raw_s = 1'b0; uses_rt_s = 1'b0; end
    endcase
  end

  assign dest_s      = (op_s == 6'h00) ? rd_s : rt_s;
  // Writes to $0 are discarded, so never advertise them downstream.
  assign reg_write_s = rw_raw_s && (dest_s != 5'd0);
  assign is_load_s   = (op_s == 6'h23);
  assign imm_s       = {{(DATA_WIDTH-16){imm16_s[15]}}, imm16_s};

  // Writeback bypass: the register file commits wb_data only at the next
  // edge, so a same-cycle write to rs/rt must be forwarded here. $0 is
  // excluded so it always reads the register file's hard zero.
  always_comb begin
    if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs_s)) begin
      opa_s = bus.wb_data;
    end else begin
      opa_s = bus.rf_data1;
    end
    if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rt_s)) begin
      opb_s = bus.wb_data;
    end else begin
      opb_s = bus.rf_data2;
    end
  end

  // Load-use hazard: the load in EX has no data yet for the instruction
  // being decoded.
  assign hz_s    = bus.if_valid && ex_valid_q && ex_is_load_q &&
                   (ex_dest_q != 5'd0) &&
                   ((ex_dest_q == rs_s) || (uses_rt_s && (ex_dest_q == rt_s)));
  // A flush discards the dependent instruction anyway, so no need to hold it.
  assign stall_s   = hz_s && !bus.ex_flush;
  assign bus.stall = stall_s;

  // Next-state for the ID/EX register: flush, then bubble, then capture.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_reg_write_d = 1'b0;
    ex_is_load_d   = 1'b0;
    ex_op_d        = ex_op_q;
    ex_funct_d     = ex_funct_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_dest_d      = ex_dest_q;
    if (bus.ex_flush || stall_s) begin
      // Bubble: control cleared, data fields hold their old values.
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d     = bus.if_valid;
      ex_reg_write_d = bus.if_valid && reg_write_s;
      ex_is_load_d   = bus.if_valid && is_load_s;
      ex_op_d        = op_s;
      ex_funct_d     = funct_s;
      ex_rs_data_d   = opa_s;
      ex_rt_data_d   = opb_s;
      ex_imm_d       = imm_s;
      ex_dest_d      = dest_s;
    end
  end

  // Saturating stall counter next-state.
  always_comb begin
    if (stall_s && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // ID/EX register and stall counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_op_q        <= 6'd0;
      ex_funct_q     <= 6'd0;
      ex_rs_data_q   <= {DATA_WIDTH{1'b0}};
      ex_rt_data_q   <= {DATA_WIDTH{1'b0}};
      ex_imm_q       <= {DATA_WIDTH{1'b0}};
      ex_dest_q      <= 5'd0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      stall_count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op_q        <= ex_op_d;
      ex_funct_q     <= ex_funct_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_dest_q      <= ex_dest_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_op        = ex_op_q;
  assign bus.ex_funct     = ex_funct_q;
  assign bus.ex_rs_data   = ex_rs_data_q;
  assign bus.ex_rt_data   = ex_rt_data_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_is_load   = ex_is_load_q;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. A second instance with CNT_WIDTH=2 shares
// the same stimulus to exercise stall counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  id_ex_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  id_ex_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  assign bus2.if_valid = bus.if_valid;
  assign bus2.if_instr = bus.if_instr;
  assign bus2.ex_flush = bus.ex_flush;
  assign bus2.rf_data1 = bus.rf_data1;
  assign bus2.rf_data2 = bus.rf_data2;
  assign bus2.wb_we    = bus.wb_we;
  assign bus2.wb_rd    = bus.wb_rd;
  assign bus2.wb_data  = bus.wb_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ex_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, "_op"},    32'(bus.ex_op), 32'd0);
    chk({tag, "_funct"}, 32'(bus.ex_funct), 32'd0);
    chk({tag, "_rs"},    bus.ex_rs_data, 32'd0);
    chk({tag, "_rt"},    bus.ex_rt_data, 32'd0);
    chk({tag, "_imm"},   bus.ex_imm, 32'd0);
    chk({tag, "_dest"},  32'(bus.ex_dest), 32'd0);
    chk({tag, "_rw"},    32'(bus.ex_reg_write), 32'd0);
    chk({tag, "_ld"},    32'(bus.ex_is_load), 32'd0);
    chk({tag, "_cnt"},   32'(bus.stall_count), 32'd0);
    chk({tag, "_cnt2"},  32'(bus2.stall_count), 32'd0);
  endtask

  localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;
  localparam logic [31:0] LW_8_9     = 32'h8D280004;
  localparam logic [31:0] ADD_2_8_3  = 32'h01031020;
  localparam logic [31:0] ADD_0_0_0  = 32'h00000020;
  localparam logic [31:0] LW_0_9     = 32'h8D200004;
  localparam logic [31:0] ADD_2_0_0  = 32'h00001020;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset        = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'd0;
    bus.ex_flush = 1'b0;
    bus.rf_data1 = 32'd0;
    bus.rf_data2 = 32'd0;
    bus.wb_we    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'd0;

    // Reset for two cycles
    tick();
    tick();
    check_ex_zero("reset");
    reset = 1'b0;

    // WB bypass on rs: add $8,$9,$10 with $9 being written this cycle
    bus.if_valid = 1'b1;
    bus.if_instr = ADD_8_9_10;
    bus.rf_data1 = 32'd5;
    bus.rf_data2 = 32'd7;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'd100;
    #1;
    chk("rf_read1", 32'(bus.rf_read1), 32'd9);
    chk("rf_read2", 32'(bus.rf_read2), 32'd10);
    chk("byp_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("byp_rs",    bus.ex_rs_data, 32'd100);
    chk("byp_rt",    bus.ex_rt_data, 32'd7);
    chk("byp_dest",  32'(bus.ex_dest), 32'd8);
    chk("byp_rw",    32'(bus.ex_reg_write), 32'd1);
    chk("byp_valid", 32'(bus.ex_valid), 32'd1);
    chk("byp_op",    32'(bus.ex_op), 32'h00);
    chk("byp_funct", 32'(bus.ex_funct), 32'h20);
    chk("byp_imm",   bus.ex_imm, 32'h00004020);
    chk("byp_ld",    32'(bus.ex_is_load), 32'd0);

    // Load-use stall: lw $8,4($9) then add $2,$8,$3
    bus.wb_we    = 1'b0;
    bus.if_instr = LW_8_9;
    bus.rf_data1 = 32'h1000;
    bus.rf_data2 = 32'd0;
    #1;
    chk("lw_nostall", 32'(bus.stall), 32'd0);
    tick();
    chk("lw_ld",   32'(bus.ex_is_load), 32'd1);
    chk("lw_dest", 32'(bus.ex_dest), 32'd8);
    chk("lw_imm",  bus.ex_imm, 32'd4);
    chk("lw_op",   32'(bus.ex_op), 32'h23);
    bus.if_instr = ADD_2_8_3;
    bus.rf_data1 = 32'd11;
    bus.rf_data2 = 32'd22;
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_bubble_ld",    32'(bus.ex_is_load), 32'd0);
    chk("lu_bubble_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("lu_cnt",          32'(bus.stall_count), 32'd1);
    chk("lu_stall_clear",  32'(bus.stall), 32'd0);
    tick();
    chk("lu_add_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_add_dest",  32'(bus.ex_dest), 32'd2);
    chk("lu_add_rs",    bus.ex_rs_data, 32'd11);
    chk("lu_add_rt",    bus.ex_rt_data, 32'd22);
    chk("lu_cnt_hold",  32'(bus.stall_count), 32'd1);
    chk("lu_cnt2",      32'(bus2.stall_count), 32'd1);

    // Flush wins over stall
    bus.if_instr = LW_8_9;
    tick();
    chk("fl_ld", 32'(bus.ex_is_load), 32'd1);
    bus.if_instr = ADD_2_8_3;
    bus.ex_flush = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("fl_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_ld0",   32'(bus.ex_is_load), 32'd0);
    chk("fl_rw0",   32'(bus.ex_reg_write), 32'd0);
    chk("fl_cnt",   32'(bus.stall_count), 32'd1);
    bus.ex_flush = 1'b0;

    // Register 0 rules
    bus.if_instr = ADD_0_0_0;
    bus.rf_data1 = 32'd0;
    bus.rf_data2 = 32'd0;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'hFFFFFFFF;
    tick();
    chk("r0_rs",    bus.ex_rs_data, 32'd0);
    chk("r0_rt",    bus.ex_rt_data, 32'd0);
    chk("r0_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("r0_valid", 32'(bus.ex_valid), 32'd1);
    bus.wb_we    = 1'b0;
    bus.if_instr = LW_0_9;
    tick();
    chk("r0_lw_ld", 32'(bus.ex_is_load), 32'd1);
    chk("r0_lw_rw", 32'(bus.ex_reg_write), 32'd0);
    bus.if_instr = ADD_2_0_0;
    #1;
    chk("r0_nostall", 32'(bus.stall), 32'd0);
    tick();
    chk("r0_next_valid", 32'(bus.ex_valid), 32'd1);
    chk("r0_cnt",        32'(bus.stall_count), 32'd1);

    // Invalid instruction never stalls
    bus.if_instr = LW_8_9;
    tick();
    bus.if_valid = 1'b0;
    bus.if_instr = ADD_2_8_3;
    #1;
    chk("inv_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 32'd0);
    chk("inv_cnt",   32'(bus.stall_count), 32'd1);
    bus.if_valid = 1'b1;

    // Four more load-use stalls: 5 total, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      bus.if_instr = LW_8_9;
      tick();
      bus.if_instr = ADD_2_8_3;
      #1;
      chk("sat_stall", 32'(bus.stall), 32'd1);
      tick();
      tick();
    end
    chk("sat_cnt16", 32'(bus.stall_count), 32'd5);
    chk("sat_cnt2",  32'(bus2.stall_count), 32'd3);

    // Reset during a stall cycle
    bus.if_instr = LW_8_9;
    tick();
    bus.if_instr = ADD_2_8_3;
    #1;
    chk("rst_stall_pre", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    tick();
    check_ex_zero("rst_mid");
    reset = 1'b0;
    #1;
    chk("rst_stall_post", 32'(bus.stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
